// File: rtl/roulette_pkg.sv
// Shared types and defaults for the roulette wheel LED spin engine.
// Holds the FSM state encoding and the LEDs-per-group helper.
package roulette_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPIN  = 2'd1,
      DECEL = 2'd2,
      BLINK = 2'd3
   } state_t;

   localparam int NUM_LEDS_DEF = 38;
   localparam int IDX_W_DEF    = 6;

   // Select value 0 means group off, so each group drives 2^sel_w-1 LEDs.
   function automatic int lpg_of(input int sel_w);
      return (1 << sel_w) - 1;
   endfunction

endpackage

// File: rtl/led_group_decoder.sv
// Wheel index to muxed LED group selects; purely combinational, zero latency.
// No flow control: outputs follow cur_idx/disp_en directly.
module led_group_decoder
   import roulette_pkg::*;
#(
   parameter int NUM_LEDS   = NUM_LEDS_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int NUM_GROUPS = 6,
   parameter int SEL_W      = 3
) (
   input  logic [IDX_W-1:0]            cur_idx,
   input  logic                        disp_en,
   output logic [NUM_GROUPS*SEL_W-1:0] mux_select
);

   localparam int LPG = lpg_of(SEL_W);

   generate
      if (NUM_GROUPS * LPG < NUM_LEDS) begin : g_cfg_err
         $error("led_group_decoder: NUM_GROUPS*LPG smaller than NUM_LEDS");
      end
   endgenerate

   // Range compare per group avoids a divider on the index path.
   always_comb begin
      mux_select = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (disp_en && (int'(cur_idx) >= g * LPG) && (int'(cur_idx) < (g + 1) * LPG)) begin
            mux_select[g*SEL_W +: SEL_W] = SEL_W'(int'(cur_idx) - g * LPG + 1);
         end
      end
   end

endmodule

// File: rtl/roulette_wheel_spinner.sv
// Spin engine: constant-speed laps, deceleration, landing on target, blink.
// busy follows accept by one cycle; start while busy is dropped, no backpressure.
module roulette_wheel_spinner
   import roulette_pkg::*;
#(
   parameter int NUM_LEDS    = NUM_LEDS_DEF,
   parameter int IDX_W       = IDX_W_DEF,
   parameter int NUM_GROUPS  = 6,
   parameter int SEL_W       = 3,
   parameter int STEP_BASE   = 500000,
   parameter int STEP_INC    = 250000,
   parameter int STEP_MAX    = 5000000,
   parameter int MIN_LAPS    = 2,
   parameter int BLINK_HALF  = 12500000,
   parameter int BLINK_COUNT = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [IDX_W-1:0]            target_idx,
   output logic                        busy,
   output logic                        done,
   output logic                        bad_target,
   output logic [IDX_W-1:0]            cur_idx,
   output logic                        disp_en,
   output logic [NUM_GROUPS*SEL_W-1:0] mux_select
);

   localparam int PER_MAX = (STEP_BASE > STEP_MAX) ? STEP_BASE : STEP_MAX;
   localparam int PER_W   = $clog2(PER_MAX + 1);
   localparam int SUM_W   = $clog2(PER_MAX + STEP_INC + 1);
   localparam int LAP_W   = $clog2(MIN_LAPS + 1);
   localparam int BLK_W   = $clog2(BLINK_HALF + 1);
   localparam int PH_W    = $clog2(2 * BLINK_COUNT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cur_q, cur_d, tgt_q, tgt_d;
   logic [PER_W-1:0]   step_q, step_d, period_q, period_d;
   logic [LAP_W-1:0]   laps_q, laps_d;
   logic [BLK_W-1:0]   blink_q, blink_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic               disp_q, disp_d, busy_q, busy_d, done_q, done_d, bad_q, bad_d;

   logic               step_hit;
   logic [IDX_W-1:0]   nxt_idx;
   logic [SUM_W-1:0]   per_sum;
   logic [PER_W-1:0]   per_next;

   always_comb begin
      nxt_idx  = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;
      per_sum  = SUM_W'(period_q) + SUM_W'(STEP_INC);
      per_next = (per_sum > SUM_W'(STEP_MAX)) ? PER_W'(STEP_MAX) : PER_W'(per_sum);
      step_hit = (step_q == period_q - 1'b1);

      state_d  = state_q;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      step_d   = step_q;
      period_d = period_q;
      laps_d   = laps_q;
      blink_d  = blink_q;
      phase_d  = phase_q;
      disp_d   = disp_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      bad_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if ({1'b0, target_idx} < (IDX_W + 1)'(NUM_LEDS)) begin
                  tgt_d    = target_idx;
                  step_d   = '0;
                  period_d = PER_W'(STEP_BASE);
                  laps_d   = '0;
                  disp_d   = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = SPIN;
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         SPIN, DECEL: begin
            if (step_hit) begin
               step_d = '0;
               cur_d  = nxt_idx;
               if (state_q == SPIN) begin
                  if (cur_q == LAST_IDX) begin
                     laps_d = laps_q + 1'b1;
                     if (laps_d == LAP_W'(MIN_LAPS)) begin
                        state_d  = DECEL;
                        period_d = per_next;
                     end
                  end
               end else begin
                  period_d = per_next;
               end
               // Landing only counts once the required laps are done.
               if ((state_d == DECEL) && (nxt_idx == tgt_q)) begin
                  state_d = BLINK;
                  blink_d = '0;
                  phase_d = '0;
                  disp_d  = 1'b1;
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         BLINK: begin
            if (blink_q == BLK_W'(BLINK_HALF - 1)) begin
               blink_d = '0;
               if (phase_q == PH_W'(2 * BLINK_COUNT - 1)) begin
                  disp_d  = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  phase_d = phase_q + 1'b1;
                  disp_d  = ~disp_q;
               end
            end else begin
               blink_d = blink_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         tgt_q    <= '0;
         step_q   <= '0;
         period_q <= '0;
         laps_q   <= '0;
         blink_q  <= '0;
         phase_q  <= '0;
         disp_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         step_q   <= step_d;
         period_q <= period_d;
         laps_q   <= laps_d;
         blink_q  <= blink_d;
         phase_q  <= phase_d;
         disp_q   <= disp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bad_q    <= bad_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign bad_target = bad_q;
   assign cur_idx    = cur_q;
   assign disp_en    = disp_q;

   led_group_decoder #(
      .NUM_LEDS  (NUM_LEDS),
      .IDX_W     (IDX_W),
      .NUM_GROUPS(NUM_GROUPS),
      .SEL_W     (SEL_W)
   ) u_dec (
      .cur_idx   (cur_q),
      .disp_en   (disp_q),
      .mux_select(mux_select)
   );

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Directed bench for roulette_wheel_spinner with short timing parameters.
// Landing targets are queued at accept and compared when done pulses.
module tb_roulette_wheel_spinner;

   localparam int NL    = 38;
   localparam int BASE  = 4;
   localparam int INC   = 2;
   localparam int MAXP  = 10;
   localparam int MINL  = 1;
   localparam int BH    = 3;
   localparam int BC    = 2;
   localparam int BLINK_TOT = 2 * BC * BH;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  target_idx;
   logic        busy, done, bad_target, disp_en;
   logic [5:0]  cur_idx;
   logic [17:0] mux_select;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_q[$];
   logic dh [0:1023];
   logic [37:0] seen;
   bit hit37, hit6, hit7;

   roulette_wheel_spinner #(
      .NUM_LEDS(NL), .IDX_W(6), .NUM_GROUPS(6), .SEL_W(3),
      .STEP_BASE(BASE), .STEP_INC(INC), .STEP_MAX(MAXP), .MIN_LAPS(MINL),
      .BLINK_HALF(BH), .BLINK_COUNT(BC)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .target_idx(target_idx),
      .busy(busy), .done(done), .bad_target(bad_target), .cur_idx(cur_idx),
      .disp_en(disp_en), .mux_select(mux_select)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] dec_model(input int idx, input logic en);
      logic [17:0] m;
      m = '0;
      if (en) m[(idx / 7) * 3 +: 3] = 3'(idx % 7 + 1);
      return m;
   endfunction

   function automatic int exp_land(input int s, input int t);
      int idx, per, laps, cnt;
      bit dec;
      idx = s; per = BASE; laps = 0; cnt = 0; dec = 0;
      for (int n = 0; n < 1000; n++) begin
         cnt += per;
         idx = (idx + 1) % NL;
         if (!dec) begin
            if (idx == 0) begin
               laps++;
               if (laps == MINL) begin
                  dec = 1;
                  per = (per + INC > MAXP) ? MAXP : per + INC;
                  if (idx == t) return cnt;
               end
            end
         end else begin
            if (idx == t) return cnt;
            per = (per + INC > MAXP) ? MAXP : per + INC;
         end
      end
      return -1;
   endfunction

   // Called at 1ns after an edge; returns 1ns after the accept edge.
   task automatic start_spin(input logic [5:0] t);
      start = 1'b1;
      target_idx = t;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic run_spin(input int inj_at, input logic [5:0] inj_tgt, input bit sweep,
                           output int land_off, output int done_off, output int busy_low,
                           output int bad_seen);
      logic [5:0] prev;
      int nz;
      prev = cur_idx;
      land_off = -1; done_off = -1; busy_low = 0; bad_seen = 0;
      for (int i = 1; i <= 700; i++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (cur_idx !== prev) land_off = i;
         prev = cur_idx;
         dh[i] = disp_en;
         if (bad_target) bad_seen++;
         chk("decode", mux_select, dec_model(int'(cur_idx), disp_en));
         if (sweep) begin
            seen[cur_idx] = 1'b1;
            if (disp_en) begin
               nz = 0;
               for (int g = 0; g < 6; g++) if (mux_select[g*3 +: 3] != 0) nz++;
               chk("one_group", nz, 1);
            end
            if (cur_idx == 37 && !hit37) begin hit37 = 1; chk("idx37", mux_select, 18'h18000); end
            if (cur_idx == 6 && !hit6) begin hit6 = 1; chk("idx6", mux_select, 18'h00007); end
            if (cur_idx == 7 && !hit7) begin hit7 = 1; chk("idx7", mux_select, 18'h00008); end
         end
         if (done) begin
            done_off = i;
            break;
         end
         if (!busy) busy_low++;
         if (i == inj_at) begin
            start = 1'b1;
            target_idx = inj_tgt;
         end
      end
      chk("timeout", (done_off < 0), 0);
   endtask

   task automatic sb_check();
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) chk("land_idx", cur_idx, exp_q.pop_front());
   endtask

   initial begin
      int land, dn, bl, bs;
      reset = 1'b1; start = 1'b0; target_idx = '0;
      seen = '0; hit37 = 0; hit6 = 0; hit7 = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_cur", cur_idx, 0);
      chk("rst_disp", disp_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bad", bad_target, 0);
      chk("rst_mux", mux_select, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Spin to 5 from 0
      start_spin(6'd5); exp_q.push_back(5);
      chk("t1_busy_rise", busy, 1);
      run_spin(-1, '0, 0, land, dn, bl, bs);
      chk("t1_land_cyc", land, 196);
      chk("t1_done_cyc", dn, 196 + BLINK_TOT);
      chk("t1_busy_low", bl, 0);
      chk("t1_bad", bs, 0);
      sb_check();
      chk("t1_mux", mux_select, 18'h00006);
      chk("t1_busy_end", busy, 0);
      chk("t1_disp_end", disp_en, 1);
      @(posedge clock); #1;
      chk("t1_done_pulse", done, 0);

      // Out-of-range target rejected
      start_spin(6'd40);
      chk("t3_bad", bad_target, 1);
      chk("t3_busy", busy, 0);
      chk("t3_cur", cur_idx, 5);
      chk("t3_mux", mux_select, dec_model(5, 1'b1));
      @(posedge clock); #1;
      chk("t3_bad_pulse", bad_target, 0);
      chk("t3_busy2", busy, 0);

      // Start while busy ignored
      start_spin(6'd20); exp_q.push_back(20);
      run_spin(50, 6'd9, 0, land, dn, bl, bs);
      chk("t4_land_cyc", land, exp_land(5, 20));
      chk("t4_bad", bs, 0);
      chk("t4_busy_low", bl, 0);
      sb_check();

      // Reset mid-spin aborts
      start_spin(6'd7); exp_q.push_back(7);
      dn = 0;
      for (int i = 1; i < 100; i++) begin
         @(posedge clock); #1;
         if (done) dn++;
      end
      @(posedge clock); #1;
      chk("t5_busy_pre", busy, 1);
      chk("t5_done_pre", dn, 0);
      reset = 1'b1;
      #1;
      chk("t5_cur", cur_idx, 0);
      chk("t5_disp", disp_en, 0);
      chk("t5_mux", mux_select, 0);
      chk("t5_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1;
      chk("t5_done", done, 0);
      reset = 1'b0;

      // Target 0 lands on the lap-completing wrap
      @(posedge clock); #1;
      start_spin(6'd0); exp_q.push_back(0);
      run_spin(-1, '0, 0, land, dn, bl, bs);
      chk("t2_land_cyc", land, 152);
      chk("t2_done_cyc", dn, 152 + BLINK_TOT);
      sb_check();
      if (land >= 0) begin
         for (int j = 0; j <= BLINK_TOT; j++)
            chk("t2_blink", dh[land + j], (j == BLINK_TOT) ? 1 : (((j / BH) % 2) == 0));
      end

      // Sweep every index
      @(posedge clock); #1;
      seen = '0;
      seen[cur_idx] = 1'b1;
      start_spin(6'd37); exp_q.push_back(37);
      run_spin(-1, '0, 1, land, dn, bl, bs);
      chk("t6_land_cyc", land, exp_land(0, 37));
      sb_check();
      chk("t6_seen", {26'b0, seen}, 64'h3F_FFFF_FFFF);
      chk("t6_hits", {hit37, hit6, hit7}, 3'b111);
      chk("t6_mux", mux_select, 18'h18000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
